serial_mod_detector: RTL and testbench
======================================

Name: serial_mod_detector

Overview:
- Parametrised successor to the divisible-by-3 serial FSM.
- Consumes a serial bit stream and tracks value mod DIVISOR for any DIVISOR >= 2.
- Supports MSB-first and LSB-first framing, a valid qualifier and explicit frame restart.
- Asserts y whenever the value accumulated so far in the current frame is divisible by DIVISOR. Sits beside the FSM3 family as the general serial divisibility checker.

Parameters:
- DIVISOR, 3, modulus; legal range 2..255; elaboration error outside range.
- RW, $clog2(DIVISOR), remainder width (derived, not overridden).
- CNT_W, 8, bit counter width (used only with optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
- in_valid  input  1  qualifies x, frame_start and lsb_first; nothing advances when 0.
- x  input  1  serial data bit.
- frame_start  input  1  with in_valid: this bit is the first bit of a new frame.
- lsb_first  input  1  frame bit order (0 = MSB-first, 1 = LSB-first); latched on the first bit of a frame.
- y  output  1  1 = current frame value divisible by DIVISOR.
- remainder  output  RW  current frame value mod DIVISOR.
- active  output  1  1 = a frame is in progress.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; y=0, remainder=0, active=0; internal weight p=1, latched mode=0.
  - Reset overrides all inputs, including in_valid in the same cycle.
- States: IDLE (no bit accepted since reset), RUN (frame in progress).
- Accepted bit = posedge with rst=1 and in_valid=1.
- First bit of frame = accepted bit while in IDLE, or accepted bit with frame_start=1 in either state.
  - Uses r_prev=0, p=1.
  - Latches lsb_first.
  - Moves to RUN.
- MSB-first update: t = 2*r_prev + x; r = (t >= DIVISOR) ? t - DIVISOR : t. One conditional subtract only, no divider.
- LSB-first update:
  - t = r_prev + (x ? p : 0); r = (t >= DIVISOR) ? t - DIVISOR : t.
  - Then q = 2*p; p = (q >= DIVISOR) ? q - DIVISOR : q.
  - p is the weight of the next bit mod DIVISOR, so p is never 0 for odd DIVISOR.
- Internal sums need RW+1 bits; no overflow is possible.
- Latency:
  - remainder, y and active update at the posedge that accepts the bit and are registered outputs.
  - y = (remainder == 0) && active. y is 0 in IDLE even though remainder=0.
- in_valid=0: all state and outputs hold indefinitely. frame_start and lsb_first are ignored.
- frame_start=1 with in_valid=0: ignored, frame continues.
- lsb_first changes mid-frame: ignored until the next first bit.
- Leading zeros (MSB-first): remainder stays 0, y=1 from the first accepted 0 bit.
- Unbounded frame length: arithmetic stays correct for any length; no wrap issues.
- Reset mid-frame: returns to IDLE. The next accepted bit starts a new frame regardless of frame_start.

Optional Feature:
- Macro SERIAL_MOD_BITCNT_EN.
- When defined:
  - Adds output port bit_cnt [CNT_W-1:0].
  - bit_cnt=1 on the first bit of a frame, +1 per further accepted bit, saturating at 2^CNT_W-1.
  - Reset value 0; holds when in_valid=0.
- When undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
1. Reset / MSB-first, DIVISOR=3: rst=0 for 2 cycles -> y=0, remainder=0, active=0. Then MSB-first bits 1,1,0 (values 1,3,6) -> remainder 1,0,0; y 0,1,1.
2. LSB-first, DIVISOR=3: lsb_first=1, bits 1,0,1 (values 1,1,5) -> remainder 1,1,2; y 0,0,0. Then bit 1 (value 13) -> remainder 1, y=0.
3. MSB-first, DIVISOR=5: bits 1,0,1,0 (1,2,5,10) -> remainder 1,2,0,0; y 0,0,1,1. With SERIAL_MOD_BITCNT_EN, bit_cnt 1,2,3,4.
4. Valid gaps and restart: mid-frame in_valid=0 for 3 cycles with x and frame_start toggling -> outputs hold. Then in_valid=1, frame_start=1, x=1 -> remainder=1, y=0, bit_cnt=1.
5. Reset mid-frame: at remainder=2, rst=0 together with in_valid=1 -> next cycle y=0, remainder=0, active=0. First valid bit x=0 after release -> active=1, y=1.
6. Random stream: 200 random bits with random in_valid, frame_start and lsb_first, DIVISOR in {3,7,10} -> y and remainder match a behavioural model (value mod DIVISOR) every cycle.

Source files
------------

// File: rtl/serial_mod_detector.sv
`default_nettype none
// ============================================================================
// Module      : serial_mod_detector
// Description : Serial divisibility checker. Tracks the value of the bits
//               accepted so far in the current frame modulo DIVISOR, in either
//               MSB-first or LSB-first order, and flags divisibility on y.
//               Optional macro SERIAL_MOD_BITCNT_EN adds a saturating
//               per-frame bit counter on output bit_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mod_detector #(
    parameter int DIVISOR = 3,
    parameter int RW      = $clog2(DIVISOR),
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          x,
    input  logic          frame_start,
    input  logic          lsb_first,
    output logic          y,
    output logic [RW-1:0] remainder,
    output logic          active
`ifdef SERIAL_MOD_BITCNT_EN
    ,
    output logic [CNT_W-1:0] bit_cnt
`endif
);

    // Elaboration-time guard on the legal parameter range
    if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
        $error("serial_mod_detector: DIVISOR must be in 2..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("serial_mod_detector: CNT_W must be at least 1");
    end

    // Sums carry one extra bit so 2*r+1 and r+p never overflow.
    localparam logic [RW:0] C_DIV = (RW + 1)'(DIVISOR);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [RW-1:0]   p_q, p_d;
    logic            lsb_q, lsb_d;
    logic            y_q, y_d;

    logic            w_first;
    logic [RW-1:0]   w_r_prev;
    logic [RW-1:0]   w_p_cur;
    logic            w_mode;
    logic [RW:0]     w_t;
    logic [RW:0]     w_q2;

    // Next-state, remainder and weight update for one accepted bit
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        p_d      = p_q;
        lsb_d    = lsb_q;
        y_d      = y_q;
        w_first  = in_valid && ((state_q == IDLE) || frame_start);
        w_r_prev = w_first ? '0 : rem_q;
        w_p_cur  = w_first ? RW'(1) : p_q;
        w_mode   = w_first ? lsb_first : lsb_q;
        w_t      = '0;
        w_q2     = {w_p_cur, 1'b0};

        if (w_mode) begin
            w_t = {1'b0, w_r_prev} + (x ? {1'b0, w_p_cur} : '0);
        end else begin
            w_t = {w_r_prev, 1'b0} + {{RW{1'b0}}, x};
        end

        if (in_valid) begin
            state_d = RUN;
            lsb_d   = w_mode;
            rem_d   = (w_t >= C_DIV) ? RW'(w_t - C_DIV) : RW'(w_t);
            // Weight of the next bit only matters in LSB-first frames;
            // in MSB-first frames it is harmless to keep advancing it.
            p_d     = (w_q2 >= C_DIV) ? RW'(w_q2 - C_DIV) : RW'(w_q2);
            y_d     = (rem_d == '0);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            p_q     <= RW'(1);
            lsb_q   <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            p_q     <= p_d;
            lsb_q   <= lsb_d;
            y_q     <= y_d;
        end
    end

    assign y         = y_q;
    assign remainder = rem_q;
    assign active    = (state_q == RUN);

`ifdef SERIAL_MOD_BITCNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Per-frame bit counter: restarts at 1 on a first bit, saturates at max
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (in_valid) begin
            if (w_first) begin
                cnt_q <= CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bit_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_mod_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mod_detector
// Description : Scoreboard bench. Four instances (DIVISOR 3,5,7,10) share one
//               input stream; a reference model keeps the frame's bits and
//               computes value mod D with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mod_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic x = 1'b0;
    logic frame_start = 1'b0;
    logic lsb_first = 1'b0;

    logic       y3, y5, y7, y10;
    logic       a3, a5, a7, a10;
    logic [1:0] r3;
    logic [2:0] r5;
    logic [2:0] r7;
    logic [3:0] r10;
`ifdef SERIAL_MOD_BITCNT_EN
    logic [7:0] c3, c5, c7, c10;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_mod_detector #(.DIVISOR(3)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .frame_start(frame_start), .lsb_first(lsb_first),
        .y(y3), .remainder(r3), .active(a3)
`ifdef SERIAL_MOD_BITCNT_EN
        , .bit_cnt(c3)
`endif
    );
    serial_mod_detector #(.DIVISOR(5)) u_d5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .frame_start(frame_start), .lsb_first(lsb_first),
        .y(y5), .remainder(r5), .active(a5)
`ifdef SERIAL_MOD_BITCNT_EN
        , .bit_cnt(c5)
`endif
    );
    serial_mod_detector #(.DIVISOR(7)) u_d7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .frame_start(frame_start), .lsb_first(lsb_first),
        .y(y7), .remainder(r7), .active(a7)
`ifdef SERIAL_MOD_BITCNT_EN
        , .bit_cnt(c7)
`endif
    );
    serial_mod_detector #(.DIVISOR(10)) u_d10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .frame_start(frame_start), .lsb_first(lsb_first),
        .y(y10), .remainder(r10), .active(a10)
`ifdef SERIAL_MOD_BITCNT_EN
        , .bit_cnt(c10)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int r3, r5, r7, r10;
        bit act;
        int cnt;
    } exp_t;

    exp_t sb[$];

    bit m_active = 1'b0;
    bit m_lsb    = 1'b0;
    int m_cnt    = 0;
    bit m_bits[$];

    function automatic int frame_mod(int d);
        int v = 0;
        int w = 1;
        for (int i = 0; i < m_bits.size(); i++) begin
            if (m_lsb) begin
                v = (v + (m_bits[i] ? w : 0)) % d;
                w = (w * 2) % d;
            end else begin
                v = (v * 2 + int'(m_bits[i])) % d;
            end
        end
        return v;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit xb,
                              input bit fs, input bit lb);
        exp_t e;
        if (!r) begin
            m_active = 1'b0;
            m_lsb    = 1'b0;
            m_cnt    = 0;
            m_bits.delete();
        end else if (v) begin
            if (!m_active || fs) begin
                m_bits.delete();
                m_lsb    = lb;
                m_active = 1'b1;
                m_cnt    = 0;
            end
            m_bits.push_back(xb);
            if (m_cnt < 255) m_cnt++;
        end
        e.act = m_active;
        e.cnt = m_cnt;
        e.r3  = frame_mod(3);
        e.r5  = frame_mod(5);
        e.r7  = frame_mod(7);
        e.r10 = frame_mod(10);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("active3", int'(a3), int'(e.act));
            chk("active10", int'(a10), int'(e.act));
            chk("rem3", int'(r3), e.act ? e.r3 : 0);
            chk("rem5", int'(r5), e.act ? e.r5 : 0);
            chk("rem7", int'(r7), e.act ? e.r7 : 0);
            chk("rem10", int'(r10), e.act ? e.r10 : 0);
            chk("y3", int'(y3), int'(e.act && e.r3 == 0));
            chk("y5", int'(y5), int'(e.act && e.r5 == 0));
            chk("y7", int'(y7), int'(e.act && e.r7 == 0));
            chk("y10", int'(y10), int'(e.act && e.r10 == 0));
`ifdef SERIAL_MOD_BITCNT_EN
            chk("cnt3", int'(c3), e.cnt);
            chk("cnt10", int'(c10), e.cnt);
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit v, input bit xb,
                        input bit fs, input bit lb);
        rst         = r;
        in_valid    = v;
        x           = xb;
        frame_start = fs;
        lsb_first   = lb;
        @(posedge clk);
        model_step(r, v, xb, fs, lb);
        #1;
    endtask

    initial begin
        bit b;
        int rv;
        // Reset for two cycles, in_valid high to show reset dominates
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_y", int'(y3), 0);
        chk("rst_rem", int'(r3), 0);
        chk("rst_act", int'(a3), 0);

        // MSB-first 1,1,0 -> D3 remainders 1,0,0
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_rem_a", int'(r3), 1); chk("t1_y_a", int'(y3), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_rem_b", int'(r3), 0); chk("t1_y_b", int'(y3), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_rem_c", int'(r3), 0); chk("t1_y_c", int'(y3), 1);

        // New frame MSB-first 1,0,1,0 -> D5 remainders 1,2,0,0
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_rem_a", int'(r5), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_rem_b", int'(r5), 2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_rem_c", int'(r5), 0); chk("t3_y_c", int'(y5), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_rem_d", int'(r5), 0); chk("t3_y_d", int'(y5), 1);
`ifdef SERIAL_MOD_BITCNT_EN
        chk("t3_cnt", int'(c5), 4);
`endif

        // Valid gaps with toggling x / frame_start: everything holds
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_hold_rem", int'(r5), 0); chk("t4_hold_y", int'(y5), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_restart_rem", int'(r5), 1); chk("t4_restart_y", int'(y5), 0);
`ifdef SERIAL_MOD_BITCNT_EN
        chk("t4_cnt", int'(c5), 1);
`endif

        // LSB-first 1,0,1,1 -> D3 remainders 1,1,2,1 (values 1,1,5,13)
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t2_rem_a", int'(r3), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_rem_b", int'(r3), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_rem_c", int'(r3), 2); chk("t2_y_c", int'(y3), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_rem_d", int'(r3), 1); chk("t2_y_d", int'(y3), 0);

        // Reset mid-frame at D3 remainder 2
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_rem", int'(r3), 2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_rst_rem", int'(r3), 0); chk("t5_rst_act", int'(a3), 0);
        chk("t5_rst_y", int'(y3), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_act", int'(a3), 1); chk("t5_y", int'(y3), 1);

        // Random stream
        rv = 0;
        while (rv < 200) begin
            b = ($urandom_range(0, 3) != 0);
            step(1'b1, b, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            if (b) rv++;
        end

        // Let the monitor drain, bounded
        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
